// File: rtl/keypad_encoder.sv
// Matrix keypad scanner for a 4-row x 6-column keypad.
// Drives one row low at a time, samples the synchronised columns at the
// end of each row dwell, debounces press and release, and emits a single
// {is_num, val} keycode with a one-cycle newkey strobe per press.
// While a key is held, the row stays frozen, so keys in other rows are ignored.
module keypad_encoder #(
    parameter int SCAN_DIV = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] rows,
    input  logic [5:0] cols,
    output logic       newkey,
    output logic [4:0] keycode,
    output logic       keyheld
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HELD     = 2'd3
    } state_t;

    // Returns {valid, code} for the active row; the lowest pressed column wins.
    function automatic logic [5:0] decode_key(input logic [1:0] row, input logic [5:0] cols_n);
        logic [5:0] res;
        res = 6'b000000;
        if (!cols_n[0]) begin
            res = {1'b1, 1'b1, row, 2'd0};
        end else if (!cols_n[1]) begin
            res = {1'b1, 1'b1, row, 2'd1};
        end else if (!cols_n[2]) begin
            res = {1'b1, 1'b1, row, 2'd2};
        end else if (!cols_n[3]) begin
            res = {1'b1, 1'b1, row, 2'd3};
        end else if (!cols_n[4]) begin
            case (row)
                2'd0:    res = {1'b1, 5'b01010};
                2'd1:    res = {1'b1, 5'b00011};
                2'd2:    res = {1'b1, 5'b00010};
                2'd3:    res = {1'b1, 5'b00100};
                default: res = 6'b000000;
            endcase
        end else if (!cols_n[5]) begin
            case (row)
                2'd0:    res = {1'b1, 5'b00001};
                2'd1:    res = {1'b1, 5'b01001};
                2'd2:    res = {1'b1, 5'b01100};
                default: res = 6'b000000;   // r3,c5 is not a key
            endcase
        end else begin
            res = 6'b000000;
        end
        return res;
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic [5:0]      r_cols_meta;
    logic [5:0]      r_cols_sync;
    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_row;
    logic [3:0]      r_rows;
    logic [4:0]      r_cand;
    logic [CW-1:0]   r_match;
    logic [CW-1:0]   r_release;
    logic            r_newkey;
    logic [4:0]      r_keycode;
    logic            r_keyheld;

    logic [5:0]      w_dec;
    logic            w_valid;
    logic [4:0]      w_code;
    logic            w_sample;
    logic            w_advance;
    logic [4:0]      w_cand_nx;
    logic [CW-1:0]   w_match_nx;
    logic [CW-1:0]   w_release_nx;
    logic            w_newkey_nx;
    logic [4:0]      w_keycode_nx;
    logic            w_keyheld_nx;

    assign w_dec    = decode_key(r_row, r_cols_sync);
    assign w_valid  = w_dec[5];
    assign w_code   = w_dec[4:0];
    assign w_sample = (r_dwell == DW'(SCAN_DIV - 1));

    assign rows    = r_rows;
    assign newkey  = r_newkey;
    assign keycode = r_keycode;
    assign keyheld = r_keyheld;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and next-output logic; newkey/keyheld are loaded on entry to EMIT.
    always_comb begin
        w_state_nx   = r_state;
        w_cand_nx    = r_cand;
        w_match_nx   = r_match;
        w_release_nx = r_release;
        w_advance    = 1'b0;
        w_newkey_nx  = 1'b0;
        w_keycode_nx = r_keycode;
        w_keyheld_nx = r_keyheld;
        case (r_state)
            ST_SCAN: begin
                if (w_sample && w_valid) begin
                    w_cand_nx  = w_code;
                    w_match_nx = CW'(1);
                    if (DEBOUNCE == 1) begin
                        w_state_nx   = ST_EMIT;
                        w_newkey_nx  = 1'b1;
                        w_keycode_nx = w_code;
                        w_keyheld_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_DEBOUNCE;
                    end
                end else if (w_sample) begin
                    w_advance = 1'b1;
                end else begin
                    w_advance = 1'b0;
                end
            end
            ST_DEBOUNCE: begin
                if (w_sample && w_valid && (w_code == r_cand)) begin
                    w_match_nx = r_match + CW'(1);
                    if (r_match == CW'(DEBOUNCE - 1)) begin
                        w_state_nx   = ST_EMIT;
                        w_newkey_nx  = 1'b1;
                        w_keycode_nx = r_cand;
                        w_keyheld_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_DEBOUNCE;
                    end
                end else if (w_sample) begin
                    w_state_nx = ST_SCAN;
                    w_match_nx = CW'(0);
                    w_advance  = 1'b1;
                end else begin
                    w_state_nx = ST_DEBOUNCE;
                end
            end
            ST_EMIT: begin
                w_state_nx   = ST_HELD;
                w_match_nx   = CW'(0);
                w_release_nx = CW'(0);
            end
            ST_HELD: begin
                if (w_sample && w_valid) begin
                    w_release_nx = CW'(0);
                end else if (w_sample) begin
                    if (r_release == CW'(DEBOUNCE - 1)) begin
                        w_state_nx   = ST_SCAN;
                        w_release_nx = CW'(0);
                        w_keyheld_nx = 1'b0;
                        w_advance    = 1'b1;
                    end else begin
                        w_release_nx = r_release + CW'(1);
                    end
                end else begin
                    w_release_nx = r_release;
                end
            end
            default: begin
                w_state_nx = ST_SCAN;
            end
        endcase
    end

    // Column synchroniser, dwell counter, row drive and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cols_meta <= 6'h3F;
            r_cols_sync <= 6'h3F;
            r_dwell     <= DW'(0);
            r_row       <= 2'd0;
            r_rows      <= 4'b1110;
            r_cand      <= 5'b00000;
            r_match     <= CW'(0);
            r_release   <= CW'(0);
            r_newkey    <= 1'b0;
            r_keycode   <= 5'b00000;
            r_keyheld   <= 1'b0;
        end else begin
            r_cols_meta <= cols;
            r_cols_sync <= r_cols_meta;
            r_dwell     <= w_sample ? DW'(0) : (r_dwell + DW'(1));
            if (w_advance) begin
                r_row  <= r_row + 2'd1;
                r_rows <= {r_rows[2:0], r_rows[3]};
            end else begin
                r_row  <= r_row;
                r_rows <= r_rows;
            end
            r_cand      <= w_cand_nx;
            r_match     <= w_match_nx;
            r_release   <= w_release_nx;
            r_newkey    <= w_newkey_nx;
            r_keycode   <= w_keycode_nx;
            r_keyheld   <= w_keyheld_nx;
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed testbench for keypad_encoder (SCAN_DIV=8, DEBOUNCE=3).
// A behavioural keypad matrix turns the driven rows and the pressed-key
// table into active-low column levels; a monitor counts newkey pulses.
module tb_keypad_encoder;

    logic       clock;
    logic       reset;
    logic [3:0] rows;
    logic [5:0] cols;
    logic       newkey;
    logic [4:0] keycode;
    logic       keyheld;

    logic [3:0][5:0] key_mat;

    int checks = 0;
    int errors = 0;

    int         pulse_cnt = 0;
    logic [4:0] last_code = 5'b00000;
    logic       prev_nk   = 1'b0;
    int         dbl_cnt   = 0;
    int         noheld_cnt = 0;

    keypad_encoder #(.SCAN_DIV(8), .DEBOUNCE(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .newkey  (newkey),
        .keycode (keycode),
        .keyheld (keyheld)
    );

    // Clock generator, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 6'h3F;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) cols = cols & ~key_mat[r];
        end
    end

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clock) begin
        prev_nk <= newkey;
        if (newkey) begin
            pulse_cnt <= pulse_cnt + 1;
            last_code <= keycode;
            if (prev_nk) dbl_cnt <= dbl_cnt + 1;
            if (!keyheld) noheld_cnt <= noheld_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pulse(input int base, input int budget, output int cyc);
        cyc = 0;
        while (pulse_cnt <= base && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic wait_held(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (keyheld !== lvl && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // Press a key pattern in one row, hold ~100 cycles, release, and check one pulse.
    task automatic press_release(input string tag, input int r, input logic [5:0] mask,
                                 input logic [4:0] exp_code);
        int base;
        int cyc;
        base = pulse_cnt;
        key_mat[r] = mask;
        wait_pulse(base, 80, cyc);
        check_eq({tag, " latency"}, 32'(cyc <= 60), 1);
        idle(100 - cyc);
        check_eq({tag, " pulses"}, pulse_cnt - base, 1);
        check_eq({tag, " code"}, 32'(last_code), 32'(exp_code));
        check_eq({tag, " held"}, 32'(keyheld), 1);
        key_mat[r] = 6'b000000;
        idle(10);
        check_eq({tag, " held after release"}, 32'(keyheld), 1);
        wait_held(1'b0, 60, cyc);
        check_eq({tag, " release seen"}, 32'(cyc < 60), 1);
        check_eq({tag, " code kept"}, 32'(keycode), 32'(exp_code));
        idle(20);
        check_eq({tag, " single pulse"}, pulse_cnt - base, 1);
    endtask

    initial begin
        int base;
        int cyc;
        logic [3:0] rprev;

        key_mat = '0;
        reset = 1'b1;
        idle(3);
        check_eq("reset rows", 32'(rows), 32'(4'b1110));
        check_eq("reset newkey", 32'(newkey), 0);
        check_eq("reset keycode", 32'(keycode), 0);
        check_eq("reset keyheld", 32'(keyheld), 0);
        reset = 1'b0;
        idle(5);

        // Single digit r2,c1.
        press_release("digit r2c1", 2, 6'b000010, 5'h19);

        // Operators and clear-all.
        press_release("op add", 0, 6'b010000, 5'b01010);
        press_release("op sub", 1, 6'b010000, 5'b00011);
        press_release("op equals", 3, 6'b010000, 5'b00100);
        press_release("clear all", 1, 6'b100000, 5'b01001);

        // Bounce: a 6-cycle toggle period means no three samples 8 cycles apart agree.
        base = pulse_cnt;
        for (int i = 0; i < 40; i++) begin
            key_mat[1] = (i % 2 == 0) ? 6'b000100 : 6'b000000;
            idle(3);
        end
        check_eq("bounce no pulse", pulse_cnt - base, 0);
        key_mat[1] = 6'b000100;
        wait_pulse(base, 80, cyc);
        check_eq("bounce pulse seen", 32'(cyc < 80), 1);
        check_eq("bounce code", 32'(last_code), 32'h16);
        idle(60);
        check_eq("bounce single", pulse_cnt - base, 1);
        key_mat[1] = 6'b000000;
        wait_held(1'b0, 60, cyc);
        idle(10);

        // Two columns in one row: lowest column wins.
        press_release("simul r3", 3, 6'b001010, 5'h1D);

        // N-key lockout: r2,c2 pressed while r0,c0 is held.
        base = pulse_cnt;
        key_mat[0] = 6'b000001;
        wait_pulse(base, 80, cyc);
        check_eq("lockout first", 32'(last_code), 32'h10);
        key_mat[2] = 6'b000100;
        idle(100);
        check_eq("lockout no second", pulse_cnt - base, 1);
        check_eq("lockout rows frozen", 32'(rows), 32'(4'b1110));
        key_mat[0] = 6'b000000;
        wait_pulse(base + 1, 120, cyc);
        check_eq("lockout second seen", 32'(cyc < 120), 1);
        check_eq("lockout second code", 32'(last_code), 32'h1A);
        key_mat[2] = 6'b000000;
        wait_held(1'b0, 60, cyc);
        idle(10);

        // Unused key r3,c5: no pulse, rows keep rotating.
        base = pulse_cnt;
        key_mat[3] = 6'b100000;
        idle(40);
        for (int k = 0; k < 4; k++) begin
            rprev = rows;
            idle(8);
            check_eq("unused rows rotate", 32'(rows), 32'({rprev[2:0], rprev[3]}));
        end
        idle(30);
        check_eq("unused no pulse", pulse_cnt - base, 0);
        key_mat[3] = 6'b000000;
        idle(10);

        // Reset while a key is held, then re-detection of the same key.
        base = pulse_cnt;
        key_mat[0] = 6'b000001;
        wait_pulse(base, 80, cyc);
        idle(5);
        check_eq("pre-reset held", 32'(keyheld), 1);
        reset = 1'b1;
        #1;
        check_eq("midreset rows", 32'(rows), 32'(4'b1110));
        check_eq("midreset keycode", 32'(keycode), 0);
        check_eq("midreset keyheld", 32'(keyheld), 0);
        check_eq("midreset newkey", 32'(newkey), 0);
        #49;
        reset = 1'b0;
        base = pulse_cnt;
        wait_pulse(base, 80, cyc);
        check_eq("post-reset seen", 32'(cyc < 80), 1);
        check_eq("post-reset code", 32'(last_code), 32'h10);
        idle(100);
        check_eq("post-reset single", pulse_cnt - base, 1);
        key_mat[0] = 6'b000000;
        wait_held(1'b0, 60, cyc);
        check_eq("post-reset release", 32'(cyc < 60), 1);

        check_eq("newkey never doubled", dbl_cnt, 0);
        check_eq("keyheld with newkey", noheld_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
